// File: rtl/truth_table_checker_if.sv
// Bus bundle for truth_table_checker: table load, evaluation, sweep and status signals.
// First-error outputs exist only when TRUTH_TABLE_CHECKER_ERR_LOG_EN is defined.
interface truth_table_checker_if #(
    parameter int unsigned N_IN = 4
);
    localparam int unsigned TW = 1 << N_IN;

    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_ready;
    logic            eval_valid;
    logic [N_IN-1:0] eval_in;
    logic            eval_out;
    logic            eval_out_valid;
    logic            sweep_start;
    logic [N_IN-1:0] sweep_vec;
    logic            sweep_resp;
    logic            sweep_busy;
    logic            sweep_done;
    logic            pass;
    logic [N_IN:0]   mismatch_cnt;
    logic [TW-1:0]   table_q;
`ifdef TRUTH_TABLE_CHECKER_ERR_LOG_EN
    logic            first_err_valid;
    logic [N_IN-1:0] first_err_idx;
`endif

    modport master (
        output cfg_valid, cfg_bit, eval_valid, eval_in, sweep_start, sweep_resp,
        input  cfg_ready, eval_out, eval_out_valid, sweep_vec, sweep_busy, sweep_done,
               pass, mismatch_cnt, table_q
`ifdef TRUTH_TABLE_CHECKER_ERR_LOG_EN
        , input first_err_valid, first_err_idx
`endif
    );

    modport slave (
        input  cfg_valid, cfg_bit, eval_valid, eval_in, sweep_start, sweep_resp,
        output cfg_ready, eval_out, eval_out_valid, sweep_vec, sweep_busy, sweep_done,
               pass, mismatch_cnt, table_q
`ifdef TRUTH_TABLE_CHECKER_ERR_LOG_EN
        , output first_err_valid, first_err_idx
`endif
    );
endinterface

// File: rtl/truth_table_checker.sv
// N-input truth-table engine: serial table load, 1-cycle evaluation and a self-timed sweep
// that checks an external netlist. TRUTH_TABLE_CHECKER_ERR_LOG_EN adds first-error capture.
module truth_table_checker #(
    parameter int unsigned           N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0]  TT_RESET = 16'h0643,
    parameter int unsigned           RESP_LAT = 2
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_checker_if.slave bus
);
    localparam int unsigned     TW       = 1 << N_IN;
    localparam logic [N_IN:0]   TW_CNT   = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {StIdle, StLoad, StSweep} state_e;

    state_e                          state_q;
    logic [TW-1:0]                   table_q;
    logic [TW-1:0]                   shadow_q;
    logic [N_IN-1:0]                 load_cnt_q;
    logic                            eval_out_q;
    logic                            eval_out_valid_q;
    logic [N_IN:0]                   k_q;
    logic [N_IN-1:0]                 sweep_vec_q;
    logic                            sweep_busy_q;
    logic                            sweep_done_q;
    logic                            pass_q;
    logic [N_IN:0]                   mismatch_cnt_q;
    logic [RESP_LAT-1:0]             pipe_v_q;
    logic [RESP_LAT-1:0][N_IN-1:0]   pipe_idx_q;
`ifdef TRUTH_TABLE_CHECKER_ERR_LOG_EN
    logic                            first_err_valid_q;
    logic [N_IN-1:0]                 first_err_idx_q;
`endif

    logic                            cfg_ready;
    logic                            cfg_accept;
    logic                            launch_v;
    logic [RESP_LAT:0]               pipe_v_all;
    logic [RESP_LAT:0][N_IN-1:0]     pipe_idx_all;
    logic                            tail_v;
    logic [N_IN-1:0]                 tail_idx;
    logic                            miss;
    logic                            last_cmp;
    logic [N_IN:0]                   mismatch_nxt;

    always_comb begin
        // A sweep request in IDLE takes priority over a concurrently offered table bit.
        cfg_ready    = (state_q != StSweep) && !((state_q == StIdle) && bus.sweep_start);
        cfg_accept   = bus.cfg_valid && cfg_ready;
        launch_v     = (state_q == StSweep) && (k_q < TW_CNT);
        pipe_v_all   = {pipe_v_q, launch_v};
        pipe_idx_all = {pipe_idx_q, k_q[N_IN-1:0]};
        tail_v       = (state_q == StSweep) && pipe_v_q[RESP_LAT-1];
        tail_idx     = pipe_idx_q[RESP_LAT-1];
        miss         = tail_v && (bus.sweep_resp != table_q[tail_idx]);
        last_cmp     = tail_v && (tail_idx == IDX_LAST);
        mismatch_nxt = mismatch_cnt_q;
        if (miss && (mismatch_cnt_q != TW_CNT)) begin
            mismatch_nxt = mismatch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            table_q          <= TT_RESET;
            shadow_q         <= '0;
            load_cnt_q       <= '0;
            eval_out_q       <= 1'b0;
            eval_out_valid_q <= 1'b0;
            k_q              <= '0;
            sweep_vec_q      <= '0;
            sweep_busy_q     <= 1'b0;
            sweep_done_q     <= 1'b0;
            pass_q           <= 1'b0;
            mismatch_cnt_q   <= '0;
            pipe_v_q         <= '0;
            pipe_idx_q       <= '0;
`ifdef TRUTH_TABLE_CHECKER_ERR_LOG_EN
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
`endif
        end else begin
            // Evaluation reads the pre-commit table, so a same-edge load commit is not visible.
            eval_out_q       <= table_q[bus.eval_in];
            eval_out_valid_q <= bus.eval_valid;
            sweep_done_q     <= 1'b0;
            pipe_v_q         <= pipe_v_all[RESP_LAT-1:0];
            pipe_idx_q       <= pipe_idx_all[RESP_LAT-1:0];

            unique case (state_q)
                StIdle, StLoad: begin
                    if ((state_q == StIdle) && bus.sweep_start) begin
                        state_q        <= StSweep;
                        k_q            <= '0;
                        sweep_vec_q    <= '0;
                        sweep_busy_q   <= 1'b1;
                        pass_q         <= 1'b0;
                        mismatch_cnt_q <= '0;
                        pipe_v_q       <= '0;
`ifdef TRUTH_TABLE_CHECKER_ERR_LOG_EN
                        first_err_valid_q <= 1'b0;
                        first_err_idx_q   <= '0;
`endif
                    end else if (cfg_accept) begin
                        if (load_cnt_q == IDX_LAST) begin
                            table_q    <= {shadow_q[TW-2:0], bus.cfg_bit};
                            shadow_q   <= '0;
                            load_cnt_q <= '0;
                            state_q    <= StIdle;
                        end else begin
                            shadow_q   <= {shadow_q[TW-2:0], bus.cfg_bit};
                            load_cnt_q <= load_cnt_q + 1'b1;
                            state_q    <= StLoad;
                        end
                    end
                end
                StSweep: begin
                    if (launch_v) begin
                        k_q <= k_q + 1'b1;
                        // Vector holds the final index once all launches are out.
                        if (k_q[N_IN-1:0] != IDX_LAST) begin
                            sweep_vec_q <= k_q[N_IN-1:0] + 1'b1;
                        end
                    end
                    mismatch_cnt_q <= mismatch_nxt;
`ifdef TRUTH_TABLE_CHECKER_ERR_LOG_EN
                    if (miss && !first_err_valid_q) begin
                        first_err_valid_q <= 1'b1;
                        first_err_idx_q   <= tail_idx;
                    end
`endif
                    if (last_cmp) begin
                        state_q      <= StIdle;
                        sweep_busy_q <= 1'b0;
                        sweep_done_q <= 1'b1;
                        pass_q       <= (mismatch_nxt == '0);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cfg_ready      = cfg_ready;
    assign bus.eval_out       = eval_out_q;
    assign bus.eval_out_valid = eval_out_valid_q;
    assign bus.sweep_vec      = sweep_vec_q;
    assign bus.sweep_busy     = sweep_busy_q;
    assign bus.sweep_done     = sweep_done_q;
    assign bus.pass           = pass_q;
    assign bus.mismatch_cnt   = mismatch_cnt_q;
    assign bus.table_q        = table_q;
`ifdef TRUTH_TABLE_CHECKER_ERR_LOG_EN
    assign bus.first_err_valid = first_err_valid_q;
    assign bus.first_err_idx   = first_err_idx_q;
`endif
endmodule
